// File: rtl/tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// tx_arb_pkg
// Shared types and limits for the Tx AXIS frame arbiter.
//   arb_state_t : arbiter FSM state (idle / frame transfer in progress)
//   MAX_SRC     : largest supported number of requesting sources
// -----------------------------------------------------------------------------
package tx_arb_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

endpackage

// File: rtl/tx_axis_arbiter_if.sv
// -----------------------------------------------------------------------------
// tx_axis_arbiter_if
// Bundles the N_SRC packed source AXIS buses, the single m00 AXIS bus towards
// tx_mac and the one-hot grant indication.
//   s_axis_*  : packed source buses, source k at [k*WIDTH +: WIDTH]
//   m00_axis_*: arbitrated stream to tx_mac s00_axis_*
//   o_grant   : one-hot current grant, 0 when idle
// Modports:
//   master : the arbiter (drives m00 data, source readies and grant)
//   slave  : the environment (sources, tx_mac sink)
// -----------------------------------------------------------------------------
interface tx_axis_arbiter_if #(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
);
    logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_SRC*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [N_SRC-1:0]            s_axis_tvalid;
    logic [N_SRC-1:0]            s_axis_tlast;
    logic [N_SRC-1:0]            s_axis_tready;

    logic [DATA_WIDTH-1:0]       m00_axis_tdata;
    logic [KEEP_WIDTH-1:0]       m00_axis_tkeep;
    logic                        m00_axis_tvalid;
    logic                        m00_axis_tlast;
    logic                        m00_axis_tready;

    logic [N_SRC-1:0]            o_grant;

    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        input  m00_axis_tready,
        output s_axis_tready,
        output m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast,
        output o_grant
    );

    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
        output m00_axis_tready,
        input  s_axis_tready,
        input  m00_axis_tdata, m00_axis_tkeep, m00_axis_tvalid, m00_axis_tlast,
        input  o_grant
    );
endinterface

// File: rtl/tx_arb_select.sv
// -----------------------------------------------------------------------------
// tx_arb_select
// Purely combinational winner selection for the Tx AXIS arbiter.
//   req      : per-source request (s_axis_tvalid)
//   last_idx : index of the source that sent the previous frame
//   winner   : selected source index (valid when any_req)
//   any_req  : at least one source is requesting
// Build option TX_ARB_STRICT_PRIO_EN:
//   defined   -> lowest-index requester wins, last_idx is ignored
//   undefined -> round-robin, search upward from last_idx+1 with wrap
// -----------------------------------------------------------------------------
module tx_arb_select #(
    parameter int N_SRC = 4,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    assign any_req = |req;

`ifdef TX_ARB_STRICT_PRIO_EN
    logic unused_last_idx;
    assign unused_last_idx = ^last_idx;

    // Scan downward so the lowest-index requester is the final assignment.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = IDX_W'(i);
            end
        end
    end
`else
    logic             found;
    logic [IDX_W-1:0] cand;

    // Candidates are visited in rotated order last_idx+1 .. last_idx+N_SRC,
    // so the previous winner is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = IDX_W'((int'(last_idx) + i) % N_SRC);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/tx_axis_arbiter.sv
// -----------------------------------------------------------------------------
// tx_axis_arbiter
// Frame-level arbiter sharing the tx_mac user AXIS input between N_SRC sources.
// A source keeps the grant from its first beat until its tlast beat has been
// accepted; frames are never interleaved.
// Ports:
//   i_clk      : Tx clock (same as tx_mac)
//   i_reset_n  : asynchronous active-low reset
//   bus        : tx_axis_arbiter_if.master (source buses, m00 bus, o_grant)
// Build option TX_ARB_STRICT_PRIO_EN selects strict priority instead of
// round-robin (handled entirely inside tx_arb_select).
// -----------------------------------------------------------------------------
module tx_axis_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    tx_axis_arbiter_if.master    bus
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
    logic [IDX_W-1:0] last_idx, last_idx_nxt;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             g_valid, g_last;

    tx_arb_select #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_select (
        .req      (bus.s_axis_tvalid),
        .last_idx (last_idx),
        .winner   (winner),
        .any_req  (any_req)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ARB_IDLE;
            grant_idx <= '0;
            last_idx  <= IDX_W'(N_SRC - 1);
        end else begin
            state     <= state_nxt;
            grant_idx <= grant_idx_nxt;
            last_idx  <= last_idx_nxt;
        end
    end

    // Outputs are all zero outside XFER, which also covers the reset case
    // because reset forces the state to IDLE asynchronously.
    always_comb begin
        state_nxt           = state;
        grant_idx_nxt       = grant_idx;
        last_idx_nxt        = last_idx;
        g_valid             = 1'b0;
        g_last              = 1'b0;
        bus.m00_axis_tdata  = '0;
        bus.m00_axis_tkeep  = '0;
        bus.m00_axis_tvalid = 1'b0;
        bus.m00_axis_tlast  = 1'b0;
        bus.s_axis_tready   = '0;
        bus.o_grant         = '0;

        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_idx_nxt = winner;
                    state_nxt     = ARB_XFER;
                end
            end
            ARB_XFER: begin
                g_valid                      = bus.s_axis_tvalid[grant_idx];
                g_last                       = bus.s_axis_tlast[grant_idx];
                bus.m00_axis_tdata           = bus.s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                bus.m00_axis_tkeep           = bus.s_axis_tkeep[grant_idx*KEEP_WIDTH +: KEEP_WIDTH];
                bus.m00_axis_tvalid          = g_valid;
                bus.m00_axis_tlast           = g_last;
                bus.s_axis_tready[grant_idx] = bus.m00_axis_tready;
                bus.o_grant[grant_idx]       = 1'b1;
                // Grant is released only once the tlast beat is actually taken.
                if (g_valid && g_last && bus.m00_axis_tready) begin
                    state_nxt    = ARB_IDLE;
                    last_idx_nxt = grant_idx;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
`timescale 1ns/1ps
module tb_tx_axis_arbiter;

    localparam int N_SRC = 4;
    localparam int DW    = 64;
    localparam int KW    = 8;

    typedef struct {
        int          src;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 i_clk = ~i_clk;

    tx_axis_arbiter_if #(.N_SRC(N_SRC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

    tx_axis_arbiter #(.N_SRC(N_SRC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    beat_t            src_q[N_SRC][$];
    beat_t            sb[$];
    logic [N_SRC-1:0] hold       = '0;
    logic [N_SRC-1:0] fired      = '0;
    int               ready_mode = 0;
    int               n_checks   = 0;
    int               n_fail     = 0;
    int               beats_seen = 0;
    bit               gap_chk    = 1'b0;
    int               post_last  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int src, input int fid, input int b, input int n);
        beat_t t;
        t.src = src;
        if (fid == 'hBB) t.data = 64'h1111 * 64'(b + 1);
        else             t.data = (64'(src) << 56) | (64'(fid) << 16) | 64'(b);
        t.last = (b == n - 1);
        t.keep = t.last ? 8'h0F : 8'hFF;
        return t;
    endfunction

    task automatic load_frame(input int src, input int fid, input int n);
        for (int b = 0; b < n; b++) src_q[src].push_back(mk_beat(src, fid, b, n));
    endtask

    task automatic exp_frame(input int src, input int fid, input int n);
        for (int b = 0; b < n; b++) sb.push_back(mk_beat(src, fid, b, n));
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int c = 0;
        while (sb.size() > 0 && c < max_cyc) begin
            @(negedge i_clk);
            c++;
        end
        check_eq(tag, 64'(sb.size()), 64'd0);
        repeat (3) @(negedge i_clk);
        #2;
    endtask

    task automatic wait_beats(input string tag, input int n, input int max_cyc);
        int start = beats_seen;
        int c = 0;
        while ((beats_seen - start) < n && c < max_cyc) begin
            @(negedge i_clk);
            #2;
            c++;
        end
        check_eq(tag, 64'(beats_seen - start), 64'(n));
    endtask

    // Source and sink models: update presented beats just after each rising edge.
    initial begin : drv
        logic [N_SRC*DW-1:0] d;
        logic [N_SRC*KW-1:0] k;
        logic [N_SRC-1:0]    v;
        logic [N_SRC-1:0]    l;
        bus.s_axis_tdata    = '0;
        bus.s_axis_tkeep    = '0;
        bus.s_axis_tvalid   = '0;
        bus.s_axis_tlast    = '0;
        bus.m00_axis_tready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            for (int s = 0; s < N_SRC; s++)
                if (fired[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
            d = '0; k = '0; v = '0; l = '0;
            for (int s = 0; s < N_SRC; s++) begin
                if (src_q[s].size() > 0 && !hold[s]) begin
                    d[s*DW +: DW] = src_q[s][0].data;
                    k[s*KW +: KW] = src_q[s][0].keep;
                    l[s]          = src_q[s][0].last;
                    v[s]          = 1'b1;
                end
            end
            bus.s_axis_tdata  = d;
            bus.s_axis_tkeep  = k;
            bus.s_axis_tvalid = v;
            bus.s_axis_tlast  = l;
            if (ready_mode == 1) bus.m00_axis_tready = ~bus.m00_axis_tready;
            else                 bus.m00_axis_tready = 1'b1;
        end
    end

    // Monitor: every beat accepted by the sink is checked against the scoreboard.
    initial begin : mon
        beat_t e;
        forever begin
            @(negedge i_clk);
            fired = bus.s_axis_tvalid & bus.s_axis_tready;
            if (post_last == 2) begin
                check_eq("next_frame_valid", 64'(bus.m00_axis_tvalid), 64'd1);
                post_last = 0;
            end
            if (post_last == 1) begin
                check_eq("idle_gap_grant", 64'(bus.o_grant), 64'd0);
                check_eq("idle_gap_valid", 64'(bus.m00_axis_tvalid), 64'd0);
                post_last = (sb.size() > 0) ? 2 : 0;
            end
            if (i_reset_n && bus.m00_axis_tvalid && bus.m00_axis_tready) begin
                beats_seen++;
                check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("beat_data",  bus.m00_axis_tdata, e.data);
                    check_eq("beat_keep",  64'(bus.m00_axis_tkeep), 64'(e.keep));
                    check_eq("beat_last",  64'(bus.m00_axis_tlast), 64'(e.last));
                    check_eq("beat_grant", 64'(bus.o_grant), 64'd1 << e.src);
                end
                if (gap_chk && bus.m00_axis_tlast) post_last = 1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin : main
        // Reset held with every source requesting
        i_reset_n = 1'b0;
        for (int s = 0; s < N_SRC; s++) load_frame(s, 1, 1);
        for (int s = 0; s < N_SRC; s++) exp_frame(s, 1, 1);
        repeat (3) begin
            @(negedge i_clk);
            #2;
            check_eq("rst_tready", 64'(bus.s_axis_tready), 64'd0);
            check_eq("rst_m_valid", 64'(bus.m00_axis_tvalid), 64'd0);
            check_eq("rst_grant", 64'(bus.o_grant), 64'd0);
        end
        i_reset_n = 1'b1;
        @(negedge i_clk);
        #2;
        check_eq("post_rst_grant", 64'(bus.o_grant), 64'b0001);
        wait_drain("drain_reset", 50);

        // Continuous 3-beat frames from every source
        gap_chk = 1'b1;
        for (int s = 0; s < N_SRC; s++) load_frame(s, 2, 3);
        load_frame(0, 3, 3);
`ifdef TX_ARB_STRICT_PRIO_EN
        exp_frame(0, 2, 3); exp_frame(0, 3, 3); exp_frame(1, 2, 3);
        exp_frame(2, 2, 3); exp_frame(3, 2, 3);
`else
        exp_frame(0, 2, 3); exp_frame(1, 2, 3); exp_frame(2, 2, 3);
        exp_frame(3, 2, 3); exp_frame(0, 3, 3);
`endif
        wait_drain("drain_rr", 100);
        gap_chk = 1'b0;

        // Sink backpressure alternating during a 5-beat frame
        ready_mode = 1;
        load_frame(1, 'hBB, 5);
        exp_frame(1, 'hBB, 5);
        wait_drain("drain_bp", 60);
        ready_mode = 0;
        repeat (2) @(negedge i_clk);
        #2;

        // Granted src2 stalls mid-frame while src0/src1 request
        load_frame(2, 4, 6);
        exp_frame(2, 4, 6);
        wait_beats("gap_first_beats", 2, 20);
        hold[2] = 1'b1;
        load_frame(0, 4, 2);
        load_frame(1, 4, 2);
        exp_frame(0, 4, 2);
        exp_frame(1, 4, 2);
        repeat (4) begin
            @(negedge i_clk);
            #2;
            check_eq("gap_grant_held", 64'(bus.o_grant), 64'b0100);
            check_eq("gap_m_valid", 64'(bus.m00_axis_tvalid), 64'd0);
        end
        hold[2] = 1'b0;
        wait_drain("drain_gap", 60);

        // Reset on the second beat of a src1 frame
        load_frame(1, 5, 4);
        exp_frame(1, 5, 0 + 4);
        void'(sb.pop_back());
        void'(sb.pop_back());
        wait_beats("rst_mid_beats", 2, 20);
        i_reset_n = 1'b0;
        #1;
        check_eq("rst_mid_m_valid", 64'(bus.m00_axis_tvalid), 64'd0);
        check_eq("rst_mid_tready", 64'(bus.s_axis_tready), 64'd0);
        check_eq("rst_mid_grant", 64'(bus.o_grant), 64'd0);
        @(posedge i_clk);
        #2;
        for (int s = 0; s < N_SRC; s++) src_q[s].delete();
        sb.delete();
        load_frame(0, 6, 2);
        load_frame(1, 6, 2);
        exp_frame(0, 6, 2);
        exp_frame(1, 6, 2);
        repeat (2) @(negedge i_clk);
        #2;
        i_reset_n = 1'b1;
        @(negedge i_clk);
        #2;
        check_eq("rst_mid_regrant", 64'(bus.o_grant), 64'b0001);
        wait_drain("drain_rst_mid", 40);

        // src0 and src3 compete with back-to-back single-beat frames
        for (int f = 0; f < 4; f++) load_frame(0, 7 + f, 1);
        for (int f = 0; f < 2; f++) load_frame(3, 7 + f, 1);
`ifdef TX_ARB_STRICT_PRIO_EN
        for (int f = 0; f < 4; f++) exp_frame(0, 7 + f, 1);
        for (int f = 0; f < 2; f++) exp_frame(3, 7 + f, 1);
`else
        exp_frame(3, 7, 1); exp_frame(0, 7, 1); exp_frame(3, 8, 1);
        exp_frame(0, 8, 1); exp_frame(0, 9, 1); exp_frame(0, 10, 1);
`endif
        wait_drain("drain_prio", 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
